// File: rtl/ca6_floating_point_div_if.sv
// Start/done handshake and operand/result bus for the CA6 floating-point divider.
// The master side issues operands and start; the slave side (the divider) returns result, done and busy.
interface ca6_floating_point_div_if;
  logic        startDiv;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        doneDiv;
  logic        busy;

  modport master (output startDiv, A, B, input result, doneDiv, busy);
  modport slave  (input startDiv, A, B, output result, doneDiv, busy);
endinterface

// File: rtl/ca6_floating_point_div.sv
// Sequential binary32 divider: 26-step radix-2 restoring divide, then one normalize/round cycle.
// Define CA6_FPDIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated toward zero.
module ca6_floating_point_div (
  input  logic clk,
  input  logic rst,
  ca6_floating_point_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  typedef enum logic [1:0] {CLS_NUM, CLS_NAN, CLS_INF, CLS_ZERO} cls_t;

  state_t             state;
  cls_t               cls;
  cls_t               cls_in;
  logic               sign;
  logic signed [9:0]  exp_diff;
  logic [23:0]        m_b;
  logic [25:0]        rem;
  logic [25:0]        quo;
  logic [4:0]         count;
  logic [31:0]        result_q;
  logic               done_q;
  logic               busy_q;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic        a_nan, a_inf, a_zero;
  logic        b_nan, b_inf, b_zero;

  assign ea     = bus.A[30:23];
  assign eb     = bus.B[30:23];
  assign a_nan  = (&ea) && (|bus.A[22:0]);
  assign a_inf  = (&ea) && !(|bus.A[22:0]);
  assign a_zero = (ea == 8'd0);
  assign b_nan  = (&eb) && (|bus.B[22:0]);
  assign b_inf  = (&eb) && !(|bus.B[22:0]);
  assign b_zero = (eb == 8'd0);

  // Special-case class in priority order: NaN, then Inf, then Zero.
  always_comb begin
    cls_in = CLS_NUM;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      cls_in = CLS_NAN;
    else if (a_inf || b_zero)
      cls_in = CLS_INF;
    else if (a_zero || b_inf)
      cls_in = CLS_ZERO;
  end

  logic        ge;
  logic [25:0] rem_sel;
  logic [25:0] rem_next;

  assign ge       = (rem >= {2'b00, m_b});
  assign rem_sel  = ge ? (rem - {2'b00, m_b}) : rem;
  assign rem_next = rem_sel << 1;

  logic [22:0]       frac_pre;
  logic [23:0]       frac_rnd;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_fin;
  logic [31:0]       norm_result;
`ifdef CA6_FPDIV_ROUND_EN
  logic              guard;
  logic              sticky;
`endif

  always_comb begin
    if (quo[25]) begin
      frac_pre = quo[24:2];
      exp_norm = exp_diff;
    end else begin
      frac_pre = quo[23:1];
      exp_norm = exp_diff - 10'sd1;
    end
`ifdef CA6_FPDIV_ROUND_EN
    guard    = quo[25] ? quo[1] : quo[0];
    sticky   = (quo[25] & quo[0]) | (|rem);
    frac_rnd = {1'b0, frac_pre} + {23'd0, guard & (sticky | frac_pre[0])};
`else
    frac_rnd = {1'b0, frac_pre};
`endif
    // A carry out of the fraction leaves frac_rnd[22:0] all zero, so only the exponent moves.
    exp_fin = frac_rnd[23] ? (exp_norm + 10'sd1) : exp_norm;

    norm_result = {sign, exp_fin[7:0], frac_rnd[22:0]};
    if (exp_fin >= 10'sd255)
      norm_result = {sign, 31'h7F80_0000};
    else if (exp_fin <= 10'sd0)
      norm_result = {sign, 31'd0};

    case (cls)
      CLS_NAN:  norm_result = 32'h7FC0_0000;
      CLS_INF:  norm_result = {sign, 31'h7F80_0000};
      CLS_ZERO: norm_result = {sign, 31'd0};
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cls      <= CLS_NUM;
      sign     <= 1'b0;
      exp_diff <= '0;
      m_b      <= '0;
      rem      <= '0;
      quo      <= '0;
      count    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.startDiv) begin
            sign     <= bus.A[31] ^ bus.B[31];
            exp_diff <= {2'b00, ea} - {2'b00, eb} + 10'd127;
            rem      <= {2'b01, bus.A[22:0]};
            m_b      <= {1'b1, bus.B[22:0]};
            quo      <= '0;
            cls      <= cls_in;
            count    <= '0;
            busy_q   <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          rem   <= rem_next;
          quo   <= {quo[24:0], ge};
          count <= count + 5'd1;
          if (count == 5'd25)
            state <= NORM;
        end
        NORM: begin
          result_q <= norm_result;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.doneDiv = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ca6_floating_point_div.sv
// Scoreboard bench for ca6_floating_point_div: directed operand pairs with hand-computed quotients.
module tb_ca6_floating_point_div;

  logic clk;
  logic rst;

  ca6_floating_point_div_if dif ();

  ca6_floating_point_div dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    logic [31:0] res;
    int          accept_edge;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   total_checks  = 0;
  int   passed_checks = 0;
  int   edge_count    = 0;
  int   done_count    = 0;
  logic prev_done     = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_count++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected)
      passed_checks++;
    else
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Monitor: pop the oldest expectation whenever the divider reports completion.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) begin
      checkOutput("doneDiv one-cycle pulse", {31'd0, dif.doneDiv}, 32'd0);
      checkOutput("busy low after done", {31'd0, dif.busy}, 32'd0);
    end
    prev_done = dif.doneDiv;
    if (dif.doneDiv === 1'b1) begin
      done_count++;
      if (sbq.size() == 0) begin
        total_checks++;
        $display("[TB] FAIL unexpected doneDiv: got result 0x%08h, expected no completion", dif.result);
      end else begin
        e = sbq.pop_front();
        checkOutput({e.name, " result"}, dif.result, e.res);
        checkOutput({e.name, " latency"}, 32'(edge_count - e.accept_edge), 32'd27);
        checkOutput({e.name, " busy with done"}, {31'd0, dif.busy}, 32'd1);
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (dif.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (dif.busy !== 1'b0) begin
      total_checks++;
      $display("[TB] FAIL idle timeout: got busy=%b, expected 0", dif.busy);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res);
    exp_t e;
    waitIdle();
    dif.startDiv = 1'b1;
    dif.A        = a;
    dif.B        = b;
    @(posedge clk); #1;
    e.res         = res;
    e.accept_edge = edge_count;
    e.name        = name;
    sbq.push_back(e);
    dif.startDiv = 1'b0;
    dif.A        = $urandom;
    dif.B        = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || dif.busy !== 1'b0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("scoreboard drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   base_done;
    logic [31:0] third;
    logic [31:0] neg_third;
`ifdef CA6_FPDIV_ROUND_EN
    third     = 32'h3EAA_AAAB;
    neg_third = 32'hBEAA_AAAB;
`else
    third     = 32'h3EAA_AAAA;
    neg_third = 32'hBEAA_AAAA;
`endif

    rst          = 1'b1;
    dif.startDiv = 1'b0;
    dif.A        = '0;
    dif.B        = '0;
    #1 rst = 1'b0;
    #2;
    checkOutput("reset result", dif.result, 32'd0);
    checkOutput("reset doneDiv", {31'd0, dif.doneDiv}, 32'd0);
    checkOutput("reset busy", {31'd0, dif.busy}, 32'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus("6/2",        32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    applyStimulus("1/3",        32'h3F80_0000, 32'h4040_0000, third);
    applyStimulus("1/-3",       32'h3F80_0000, 32'hC040_0000, neg_third);
    applyStimulus("-1/0.5",     32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000);
    applyStimulus("-6/-2",      32'hC0C0_0000, 32'hC000_0000, 32'h4040_0000);
    applyStimulus("overflow",   32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000);
    applyStimulus("underflow",  32'h0080_0000, 32'h7F00_0000, 32'h0000_0000);
    applyStimulus("1/0",        32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000);
    applyStimulus("0/0",        32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
    applyStimulus("inf/inf",    32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    applyStimulus("2/inf",      32'h4000_0000, 32'h7F80_0000, 32'h0000_0000);
    applyStimulus("nan/1",      32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    applyStimulus("denorm/1",   32'h0040_0000, 32'h3F80_0000, 32'h0000_0000);
    drain();

    // startDiv held high: second accept only once the block is back in IDLE (edge 29).
    dif.startDiv = 1'b1;
    dif.A        = 32'h40C0_0000;
    dif.B        = 32'h4000_0000;
    @(posedge clk); #1;
    e.res = 32'h4040_0000; e.accept_edge = edge_count;      e.name = "held first";
    sbq.push_back(e);
    e.res = 32'h4040_0000; e.accept_edge = edge_count + 29; e.name = "held second";
    sbq.push_back(e);
    repeat (29) @(posedge clk);
    #1;
    checkOutput("held start reaccepted", {31'd0, dif.busy}, 32'd1);
    dif.startDiv = 1'b0;
    drain();

    // Asynchronous reset at DIV iteration 10 aborts the operation with no completion.
    applyStimulus("aborted", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    void'(sbq.pop_back());
    base_done = done_count;
    checkOutput("abort result", dif.result, 32'd0);
    checkOutput("abort doneDiv", {31'd0, dif.doneDiv}, 32'd0);
    checkOutput("abort busy", {31'd0, dif.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("no done after abort", 32'(done_count - base_done), 32'd0);

    applyStimulus("6/2 after reset", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
    drain();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/ca6_floating_point_div.md
# ca6_floating_point_div

Sequential IEEE-754 single-precision divider, the inverse operation to the CA6 floating-point multiplier datapath. It computes result = A / B with a radix-2 restoring divide of the 24-bit significands, subtracts the exponents and XORs the signs. It uses the same start/done handshake as the multiplier and sits beside it in the CA6 arithmetic unit.

## Interface
- No parameters. Widths are fixed at binary32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- startDiv  in  1  request; sampled only in IDLE
- A  in  32  dividend (binary32); captured on the accepting edge
- B  in  32  divisor (binary32); captured on the accepting edge
- result  out  32  quotient (binary32); registered and held until the next completion
- doneDiv  out  1  one-cycle completion pulse
- busy  out  1  high from the accepting edge until doneDiv falls

## Operation
- States and transitions:
  - IDLE: on startDiv=1, go to DIV.
  - DIV: 26 iterations, then go to NORM.
  - NORM: go to DONE.
  - DONE: go to IDLE.
- Accept (IDLE, startDiv=1):
  - Latch the sign: sA^sB.
  - Latch the signed 10-bit exponent difference eA-eB+127.
  - Latch the significands mA={1,A[22:0]} and mB={1,B[22:0]}.
  - Latch the special-case class.
  - Clear the 5-bit counter.
- DIV: each cycle, compare the 26-bit partial remainder with mB.
  - If remainder ≥ mB, subtract and shift in 1; otherwise shift in 0.
  - Shift the remainder left for the next cycle.
  - Result: q = floor(mA·2^25 / mB), q in [2^24, 2^26). The final remainder feeds sticky.
- NORM, when q[25]=1:
  - frac=q[24:2], guard=q[1], sticky=q[0]|(rem≠0)
  - exponent unchanged
- NORM, when q[25]=0:
  - frac=q[23:1], guard=q[0], sticky=(rem≠0)
  - exponent −1
- Rounding: see Configuration. If rounding carries out of frac, exponent +1 and frac=0.
- Range checks, after rounding:
  - exponent ≥255: result is ±Inf (0x7F800000 with sign).
  - exponent ≤0: result is ±0 (flush-to-zero, no denormal output).
- Special cases are decided at accept and override the arithmetic. They still take the full latency. Priority order:
  1. NaN: either operand has exponent 255 and frac≠0; or 0/0; or Inf/Inf. Result is 0x7FC00000.
  2. Inf: A is Inf, or B is zero. Result is sign|0x7F800000.
  3. Zero: A is zero, or B is Inf. Result is sign|0x00000000.
- Operands with exponent 0 are treated as zero (denormal inputs are flushed).
- startDiv while busy is ignored. It is not queued.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE
  - result=0x00000000, doneDiv=0, busy=0
  - counter and remainder cleared
  - Takes effect immediately, including mid-operation. The aborted operation produces no doneDiv.
- Latency:
  - The accepting edge is edge 0.
  - DIV occupies edges 1–26.
  - NORM at edge 27 writes result and raises doneDiv.
  - The DONE edge (28) drops doneDiv.
  - doneDiv is high for exactly one cycle, and result is valid together with it.
- busy rises after edge 0 and falls with doneDiv.
- The earliest next accept is at edge 29, when the block is in IDLE with startDiv=1.
- Back-to-back throughput: one division per 29 cycles.
- A and B may change freely after edge 0.

## Configuration
- CA6_FPDIV_ROUND_EN defined: round to nearest, ties to even. Increment frac when guard & (sticky | frac[0]).
- CA6_FPDIV_ROUND_EN undefined: round toward zero. guard and sticky are discarded and there is no increment path.
- Latency and all special-case behaviour are identical in both builds.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000; doneDiv high exactly 27 cycles after the accepting edge, for one cycle; busy low afterwards.
- 0x3F800000 / 0x40400000 (1.0/3.0) -> 0x3EAAAAAB with CA6_FPDIV_ROUND_EN, 0x3EAAAAAA without it.
- 0xBF800000 / 0x3F000000 (−1.0/0.5) -> 0xC0000000. Then 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow). Then 0x00800000 / 0x7F000000 -> 0x00000000 (underflow).
- 0x3F800000 / 0x00000000 -> 0x7F800000. 0x00000000 / 0x00000000 -> 0x7FC00000. 0x7F800000 / 0x7F800000 -> 0x7FC00000. 0x40000000 / 0x7F800000 -> 0x00000000.
- startDiv held high across a whole operation -> the second operation is accepted only when the block is back in IDLE; pulses at intermediate edges are ignored.
- rst pulsed low at DIV iteration 10 -> result=0x00000000, doneDiv=0 and busy=0 immediately, with no doneDiv afterwards. A fresh 6.0/2.0 then completes normally.
